// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : uart_tx_pkg
//  Purpose   : Shared definitions for the UART transmit path: the frame
//              sequencer state encoding and the TX output-mux select codes.
//              The TX mux uses the same select codes, so both sides decode
//              the line level in the same way.
//  Revision  : 1.0  initial release
// ============================================================================
package uart_tx_pkg;

  // Frame sequencer states. The encoding is 3 bits wide, so three codes are
  // unused. The sequencer treats those codes as illegal and returns to IDLE.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // TX output-mux select codes.
  localparam logic [1:0] MUX_START = 2'b00;  // line driven low (start bit)
  localparam logic [1:0] MUX_DATA  = 2'b01;  // serializer output
  localparam logic [1:0] MUX_PAR   = 2'b10;  // parity bit
  localparam logic [1:0] MUX_STOP  = 2'b11;  // line driven high (stop / idle)

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : uart_tx_ctrl
//  Purpose   : UART transmit frame sequencer. One clk equals one bit period.
//              A request is accepted only in IDLE. The module then walks
//              through the frame: start bit, DATA_WIDTH data bits sent
//              LSB-first, an optional parity bit, and a stop bit. While it
//              does so it drives the serializer shift enable and bit index,
//              the TX mux select, BUSY, and a done pulse.
//  Ports     :
//    clk         in   1        TX bit clock, rising edge
//    rst         in   1        asynchronous reset, active low
//    Data_valid  in   1        byte request, accepted only in IDLE
//    Par_en      in   1        parity enable, sampled on the accept cycle
//    ser_en      out  1        serializer shift enable, high in DATA
//    ser_idx     out  clog2(W) data bit index in DATA, 0 otherwise
//    mux_sel     out  2        00 start, 01 data, 10 parity, 11 stop/idle
//    BUSY        out  1        high in START, DATA, PARITY and STOP
//    tx_done     out  1        one-cycle pulse in the STOP cycle
//  Revision  : 1.0  initial release
// ============================================================================
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Data_valid,
  input  logic                          Par_en,
  output logic                          ser_en,
  output logic [$clog2(DATA_WIDTH)-1:0] ser_idx,
  output logic [1:0]                    mux_sel,
  output logic                          BUSY,
  output logic                          tx_done
);

  localparam int             CW     = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]  C_LAST = CW'(DATA_WIDTH - 1);

  tx_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           par_en_q, par_en_d;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      par_en_q <= par_en_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic and Moore output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    par_en_d = par_en_q;
    ser_en   = 1'b0;
    ser_idx  = '0;
    mux_sel  = MUX_STOP;
    BUSY     = 1'b0;
    tx_done  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Par_en is latched here and nowhere else. A change to Par_en
        // later in the frame therefore has no effect on the parity slot.
        if (Data_valid) begin
          state_d  = START;
          par_en_d = Par_en;
        end
      end

      START: begin
        mux_sel = MUX_START;
        BUSY    = 1'b1;
        state_d = DATA;
        cnt_d   = '0;
      end

      DATA: begin
        mux_sel = MUX_DATA;
        BUSY    = 1'b1;
        ser_en  = 1'b1;
        ser_idx = cnt_q;
        // The counter stops at the last bit index and never wraps. IDLE
        // clears it before the next frame starts.
        if (cnt_q == C_LAST) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      PARITY: begin
        mux_sel = MUX_PAR;
        BUSY    = 1'b1;
        state_d = STOP;
      end

      STOP: begin
        BUSY    = 1'b1;
        tx_done = 1'b1;
        // Always return to IDLE, even if a request is pending. This
        // guarantees a BUSY-low cycle between frames, which the parity
        // calculator needs for its data capture.
        state_d = IDLE;
      end

      default: begin
        // Unused encodings: keep the line high and recover to IDLE.
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule : uart_tx_ctrl
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : tb_uart_tx_ctrl
//  Purpose   : Self-checking bench for uart_tx_ctrl with DATA_WIDTH = 8.
//              For every clock cycle, the stimulus process queues the
//              hand-derived expected output vector. A separate monitor
//              process pops each entry on the falling edge and compares it
//              with the DUT outputs.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_uart_tx_ctrl;

  typedef struct packed {
    logic [1:0] mux;
    logic       busy;
    logic       sen;
    logic [2:0] idx;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Data_valid = 1'b0;
  logic       Par_en = 1'b0;
  logic       ser_en;
  logic [2:0] ser_idx;
  logic [1:0] mux_sel;
  logic       BUSY;
  logic       tx_done;

  int n_pass  = 0;
  int n_total = 0;

  exp_t  exp_q[$];
  string tag_q[$];

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .Data_valid (Data_valid),
    .Par_en     (Par_en),
    .ser_en     (ser_en),
    .ser_idx    (ser_idx),
    .mux_sel    (mux_sel),
    .BUSY       (BUSY),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  // Expected output vectors for each state.
  function automatic exp_t e_idle();
    return '{mux: 2'b11, busy: 1'b0, sen: 1'b0, idx: 3'd0, done: 1'b0};
  endfunction
  function automatic exp_t e_start();
    return '{mux: 2'b00, busy: 1'b1, sen: 1'b0, idx: 3'd0, done: 1'b0};
  endfunction
  function automatic exp_t e_data(input int i);
    return '{mux: 2'b01, busy: 1'b1, sen: 1'b1, idx: 3'(i), done: 1'b0};
  endfunction
  function automatic exp_t e_par();
    return '{mux: 2'b10, busy: 1'b1, sen: 1'b0, idx: 3'd0, done: 1'b0};
  endfunction
  function automatic exp_t e_stop();
    return '{mux: 2'b11, busy: 1'b1, sen: 1'b0, idx: 3'd0, done: 1'b1};
  endfunction

  function automatic exp_t dut_now();
    return '{mux: mux_sel, busy: BUSY, sen: ser_en, idx: ser_idx, done: tx_done};
  endfunction

  task automatic chk(input string name, input exp_t act, input exp_t req);
    n_total++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got mux=%b busy=%b sen=%b idx=%0d done=%b, need mux=%b busy=%b sen=%b idx=%0d done=%b",
               name, act.mux, act.busy, act.sen, act.idx, act.done,
               req.mux, req.busy, req.sen, req.idx, req.done);
    end
  endtask

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, dut_now(), e);
    end
  end

  // One cycle: queue the expected outputs for the current state, then drive
  // the inputs for the next rising edge.
  task automatic cyc(input logic dv, input logic pe, input exp_t e, input string t);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    tag_q.push_back(t);
    Data_valid = dv;
    Par_en     = pe;
  endtask

  // One frame, starting from IDLE. pe_acc is the Par_en value on the accept
  // cycle. pe_rest and dv_rest are the values driven for the rest of the frame.
  task automatic frame(input logic pe_acc, input logic pe_rest, input logic dv_rest,
                       input string t);
    cyc(1'b1, pe_acc, e_idle(), {t, "_accept"});
    cyc(dv_rest, pe_rest, e_start(), {t, "_start"});
    for (int i = 0; i < 8; i++) begin
      cyc(dv_rest, pe_rest, e_data(i), $sformatf("%s_data%0d", t, i));
    end
    if (pe_acc) cyc(dv_rest, pe_rest, e_par(), {t, "_parity"});
    cyc(dv_rest, pe_rest, e_stop(), {t, "_stop"});
  endtask

  initial begin
    #2;
    chk("reset_state", dut_now(), e_idle());
    #10;
    rst = 1'b1;
    cyc(1'b0, 1'b0, e_idle(), "idle0");

    // Parity frame: 00, 01 x8, 10, 11, then idle.
    frame(1'b1, 1'b1, 1'b0, "par");
    cyc(1'b0, 1'b0, e_idle(), "par_idle0");
    cyc(1'b0, 1'b0, e_idle(), "par_idle1");

    // Frame without parity: there is no 10 code.
    frame(1'b0, 1'b0, 1'b0, "nopar");
    cyc(1'b0, 1'b0, e_idle(), "nopar_idle0");

    // Par_en drops after accept, and Data_valid stays high through the
    // frame, including STOP. Parity must still appear. The STOP request
    // must be dropped.
    frame(1'b1, 1'b0, 1'b1, "midchg");
    cyc(1'b0, 1'b0, e_idle(), "drop_idle0");
    cyc(1'b0, 1'b0, e_idle(), "drop_idle1");
    cyc(1'b0, 1'b0, e_idle(), "drop_idle2");

    // Data_valid held high: back-to-back frames with exactly one idle cycle
    // between them, giving a 12-clk period.
    for (int f = 0; f < 3; f++) begin
      frame(1'b1, 1'b1, 1'b1, $sformatf("hold%0d", f));
    end
    cyc(1'b0, 1'b0, e_idle(), "hold_idle0");
    cyc(1'b0, 1'b0, e_idle(), "hold_idle1");

    // Reset asserted at data bit 4, between clock edges.
    cyc(1'b1, 1'b0, e_idle(), "rstf_accept");
    cyc(1'b0, 1'b0, e_start(), "rstf_start");
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, e_data(i), $sformatf("rstf_data%0d", i));
    end
    @(posedge clk);
    #1;
    chk("pre_reset_data4", dut_now(), e_data(4));
    exp_q.push_back(e_idle());
    tag_q.push_back("in_reset");
    rst        = 1'b0;
    Data_valid = 1'b1;
    #1;
    chk("async_reset", dut_now(), e_idle());
    @(posedge clk);
    #1;
    exp_q.push_back(e_idle());
    tag_q.push_back("reset_hold");
    rst        = 1'b1;
    Data_valid = 1'b0;
    cyc(1'b0, 1'b0, e_idle(), "post_reset_idle");

    // A clean frame after the reset.
    frame(1'b0, 1'b0, 1'b0, "after_rst");
    cyc(1'b0, 1'b0, e_idle(), "final_idle");

    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule : tb_uart_tx_ctrl
`default_nettype wire
